led_fader: RTL and testbench
============================

# led_fader

Downstream consumer of the 8-bit rotating LED pattern register: converts each pattern bit into a PWM-driven LED with instant turn-on and stepwise fade-out, giving the moving light a decaying trail. Sits between the pattern register and the board pins LED0..LED7, clocked by the main board clock, with the pattern bus as its only data input.

## Interface
- PWM_BITS, 4: brightness resolution; levels 0..2^PWM_BITS-1 (MAX).
- FADE_DIV, 65536: CLK cycles between successive decay steps (≥2).
- CLK  input  1  board clock; all logic on rising edge.
- RSTN  input  1  reset; one clock, reset asynchronous and active-low.
- ena  input  1  run enable; low freezes all counters and levels, forces LEDs off.
- pattern  input  8  LED request bits, synchronous to CLK; bit i drives LEDi.
- LED0..LED7  output  1 each  registered PWM outputs to pins.

## Operation
- Per-channel level register lvl[i], PWM_BITS wide, unsigned.
- Fade divider: counter 0..FADE_DIV-1, +1 per cycle when ena; step = 1 for the single cycle the counter equals FADE_DIV-1, then counter wraps to 0.
- PWM counter: PWM_BITS wide, +1 per cycle when ena, natural wrap 2^PWM_BITS-1 -> 0.
- Channel states (derived from lvl): OFF (lvl=0), LIT (lvl=MAX, pattern[i]=1), DECAY (pattern[i]=0, lvl>0).
- Level update each cycle when ena, priority order:
  - pattern[i]=1 -> lvl <= MAX (any state, regardless of step).
  - else step=1 and lvl>0 -> lvl <= lvl-1.
  - else hold. lvl never underflows below 0.
- Output: LEDi <= ena & ((lvl[i]==MAX) | (pwm_cnt < lvl[i])). Duty: 0 -> 0%, k -> k/2^PWM_BITS, MAX -> 100%.
- ena low: counters and lvl hold, LEDi <= 0 next edge; on ena rising, resume from held values.
- Channels are independent; all eight may be LIT simultaneously.

## Timing
- Reset (RSTN low, async): lvl=0 all channels, fade counter 0, PWM counter 0, LED0..LED7=0. Effect immediate, not waiting for CLK.
- Release: first count on first CLK edge with RSTN high and ena high.
- Reset mid-fade: trail discarded, all LEDs off immediately; no residual brightness after release unless pattern re-asserts.
- Latency: pattern[i] high sampled at edge t -> lvl=MAX after t -> LEDi=1 after edge t+1 (1 cycle output register).
- Fall: pattern[i] low at edge t -> lvl stays MAX until next step; decays one level per step; reaches 0 after exactly MAX step pulses (first step may arrive 1..FADE_DIV cycles after the fall).
- pattern high in the same cycle as step: lvl set to MAX, no decrement.
- pattern pulse of one CLK cycle is sufficient to set MAX.
- Full fade time with defaults: 15 x 65536 cycles.

## Structure
- Shared package/header: PWM_BITS default, derived LVL_MAX = 2^PWM_BITS-1, fade counter width = clog2(FADE_DIV).
- Top led_fader holds the fade divider and PWM counter, broadcasts step and pwm_cnt.
- Sub-module fade_channel: one lvl register plus output comparator/register; instantiated 8 times (generate loop), inputs pattern bit, step, pwm_cnt, ena.

## Test plan
(PWM_BITS=2, FADE_DIV=4, MAX=3, ena=1 unless stated)
- Reset: hold RSTN low, pattern=8'hFF -> all LEDs 0, lvl=0; release -> LEDs all 1 from the 2nd edge onward, continuously (100% duty).
- Single pulse: pattern=8'h01 for 1 cycle then 8'h00 -> LED0 duty steps 100%, 50%, 25%, 0% over consecutive 4-cycle step windows; LED1..7 stay 0.
- Step collision: pattern[3] asserted exactly in the step cycle while lvl[3]=1 -> lvl[3]=3 next cycle, not 0 or 2.
- Rotation: drive 8'h01 rotating left every 8 cycles -> each LED lights on arrival, trailing LEDs show decreasing duty, no LED with lvl=0 ever pulses.
- Enable gating: deassert ena with lvl[0]=2 for 20 cycles -> all LEDs 0, lvl/counters unchanged; reassert -> LED0 resumes 50% duty from the held PWM phase.
- Async reset mid-fade: pull RSTN low between CLK edges with lvl[5]=2 -> LED5 0 immediately; after release with pattern=0 it stays 0.

Source files
------------

// File: rtl/led_fader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_fader_pkg
// Brief    : Shared defaults and derived widths for the LED fader.
// Revision : 1.0
// ============================================================================
package led_fader_pkg;

    localparam int PWM_BITS_DEF = 4;
    localparam int FADE_DIV_DEF = 65536;
    localparam int NUM_CH       = 8;

    // Channel condition as seen from outside; not stored, always derived from lvl.
    typedef enum logic [1:0] {
        CH_OFF   = 2'd0,
        CH_LIT   = 2'd1,
        CH_DECAY = 2'd2
    } ch_state_t;

    function automatic int lvl_max(input int bits);
        return (1 << bits) - 1;
    endfunction

    function automatic int fade_cnt_w(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_fader_if.sv
`default_nettype none
// ============================================================================
// Module   : led_fader_if
// Brief    : Pattern bus from the rotating pattern register into the fader.
// Revision : 1.0
// ============================================================================
interface led_fader_if;
    import led_fader_pkg::*;

    logic              ena;
    logic [NUM_CH-1:0] pattern;

    modport master (output ena, output pattern);
    modport slave  (input  ena, input  pattern);

endinterface
`default_nettype wire

// File: rtl/led_fader_fade_channel.sv
`default_nettype none
// ============================================================================
// Module   : fade_channel
// Brief    : One LED: brightness level register plus registered PWM compare.
// Revision : 1.0
// ============================================================================
module fade_channel
    import led_fader_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                ena_i,
    input  logic                pattern_i,
    input  logic                step_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    output logic                led_o
);

    localparam logic [PWM_BITS-1:0] LVL_MAX = PWM_BITS'(lvl_max(PWM_BITS));

    logic [PWM_BITS-1:0] lvl_q;
    logic [PWM_BITS-1:0] lvl_d;
    logic                led_q;
    logic                led_d;

    // A request always wins over a decay step arriving in the same cycle.
    always_comb begin
        lvl_d = lvl_q;
        if (ena_i) begin
            if (pattern_i) begin
                lvl_d = LVL_MAX;
            end else if (step_i && (lvl_q != '0)) begin
                lvl_d = lvl_q - PWM_BITS'(1);
            end
        end
    end

    // MAX is forced fully on; a plain compare would leave one dark PWM slot.
    always_comb begin
        led_d = ena_i && ((lvl_q == LVL_MAX) || (pwm_cnt_i < lvl_q));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lvl_q <= '0;
            led_q <= 1'b0;
        end else begin
            lvl_q <= lvl_d;
            led_q <= led_d;
        end
    end

    assign led_o = led_q;

endmodule
`default_nettype wire

// File: rtl/led_fader.sv
`default_nettype none
// ============================================================================
// Module   : led_fader
// Brief    : Eight PWM LEDs with instant turn-on and stepwise fade-out trail.
// Revision : 1.0
// ============================================================================
module led_fader
    import led_fader_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF,
    parameter int FADE_DIV = FADE_DIV_DEF
) (
    input  logic        CLK,
    input  logic        RSTN,
    led_fader_if.slave  bus,
    output logic        LED0,
    output logic        LED1,
    output logic        LED2,
    output logic        LED3,
    output logic        LED4,
    output logic        LED5,
    output logic        LED6,
    output logic        LED7
);

    localparam int              FCW       = fade_cnt_w(FADE_DIV);
    localparam logic [FCW-1:0]  FADE_LAST = FCW'(FADE_DIV - 1);

    logic [FCW-1:0]      fade_cnt_q;
    logic [FCW-1:0]      fade_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_d;
    logic                step;
    logic [NUM_CH-1:0]   led;

    always_comb begin
        fade_cnt_d = fade_cnt_q;
        pwm_cnt_d  = pwm_cnt_q;
        if (bus.ena) begin
            fade_cnt_d = (fade_cnt_q == FADE_LAST) ? '0 : fade_cnt_q + FCW'(1);
            pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
        end
    end

    // Single-cycle decay strobe shared by all channels.
    assign step = bus.ena && (fade_cnt_q == FADE_LAST);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            fade_cnt_q <= '0;
            pwm_cnt_q  <= '0;
        end else begin
            fade_cnt_q <= fade_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        fade_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk_i     (CLK),
            .rst_n_i   (RSTN),
            .ena_i     (bus.ena),
            .pattern_i (bus.pattern[i]),
            .step_i    (step),
            .pwm_cnt_i (pwm_cnt_q),
            .led_o     (led[i])
        );
    end

    assign LED0 = led[0];
    assign LED1 = led[1];
    assign LED2 = led[2];
    assign LED3 = led[3];
    assign LED4 = led[4];
    assign LED5 = led[5];
    assign LED6 = led[6];
    assign LED7 = led[7];

endmodule
`default_nettype wire

// File: tb/tb_led_fader.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_fader
// Brief    : Directed vector bench for led_fader at PWM_BITS=2, FADE_DIV=4.
// Revision : 1.0
// ============================================================================
module tb_led_fader;

    localparam int PB = 2;
    localparam int FD = 4;

    logic CLK;
    logic RSTN;
    logic LED0, LED1, LED2, LED3, LED4, LED5, LED6, LED7;
    logic [7:0] leds;

    assign leds = {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0};

    led_fader_if bus ();

    led_fader #(
        .PWM_BITS (PB),
        .FADE_DIV (FD)
    ) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus),
        .LED0 (LED0),
        .LED1 (LED1),
        .LED2 (LED2),
        .LED3 (LED3),
        .LED4 (LED4),
        .LED5 (LED5),
        .LED6 (LED6),
        .LED7 (LED7)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit         rst;
        logic       ena;
        logic [7:0] pat;
        logic [7:0] exp;
        int         phase;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: LEDs=%h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic void add(input bit rst, input logic ena, input logic [7:0] pat,
                                input logic [7:0] exp, input int phase);
        vec_t v;
        v.rst = rst; v.ena = ena; v.pat = pat; v.exp = exp; v.phase = phase;
        vecs.push_back(v);
    endfunction

    // Called #1 after a rising edge; leaves RSTN high with the next edge as edge 1.
    task automatic do_reset();
        RSTN = 1'b0;
        #2;
        check("reset_async", 0, leds, 8'h00);
        @(posedge CLK);
        #1;
        check("reset_hold", 0, leds, 8'h00);
        RSTN = 1'b1;
    endtask

    string pname[5] = '{"reset_release", "single_pulse", "step_collision", "rotation", "ena_gating"};

    logic [7:0] sp   [16];
    bit         c3   [20];
    logic [7:0] rot  [24];
    logic [7:0] enr  [8];

    initial begin
        RSTN        = 1'b0;
        bus.ena     = 1'b0;
        bus.pattern = 8'h00;

        sp  = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00,
                8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        c3  = '{0, 1, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0};
        rot = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01,
                8'h01, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h02, 8'h02,
                8'h03, 8'h06, 8'h06, 8'h06, 8'h06, 8'h06, 8'h04, 8'h04};
        enr = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};

        // Reset with all requests high: dark on edge 1, fully on afterwards.
        for (int k = 0; k < 9; k++)
            add(k == 0, 1'b1, 8'hFF, (k == 0) ? 8'h00 : 8'hFF, 0);
        // One-cycle pulse on bit 0, then 100/50/25/0 % windows.
        for (int k = 0; k < 16; k++)
            add(k == 0, 1'b1, (k == 0) ? 8'h01 : 8'h00, sp[k], 1);
        // Bit 3 re-requested exactly on the step edge while lvl=1.
        for (int k = 0; k < 20; k++)
            add(k == 0, 1'b1, (k == 0 || k == 11) ? 8'h08 : 8'h00, c3[k] ? 8'h08 : 8'h00, 2);
        // Rotating single bit, 8 cycles per position.
        for (int k = 0; k < 24; k++)
            add(k == 0, 1'b1, 8'h01 << (k / 8), rot[k], 3);
        // Freeze with lvl0=2 for 20 cycles, then resume from held phase.
        for (int k = 0; k < 33; k++) begin
            if (k == 0)       add(1'b1, 1'b1, 8'h01, 8'h00, 4);
            else if (k < 5)   add(1'b0, 1'b1, 8'h00, 8'h01, 4);
            else if (k < 25)  add(1'b0, 1'b0, 8'h00, 8'h00, 4);
            else              add(1'b0, 1'b1, 8'h00, enr[k - 25], 4);
        end

        @(posedge CLK);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            bus.ena     = vecs[i].ena;
            bus.pattern = vecs[i].pat;
            if (vecs[i].rst) do_reset();
            @(posedge CLK);
            #1;
            check(pname[vecs[i].phase], i, leds, vecs[i].exp);
        end

        // Async reset mid-fade on LED5, then no residual trail.
        bus.ena     = 1'b1;
        bus.pattern = 8'h00;
        RSTN        = 1'b0;
        @(posedge CLK);
        #1;
        RSTN        = 1'b1;
        bus.pattern = 8'h20;
        @(posedge CLK);
        #1;
        bus.pattern = 8'h00;
        repeat (5) @(posedge CLK);
        #1;
        check("midfade_before", 0, leds, 8'h20);
        #2;
        RSTN = 1'b0;
        #1;
        check("midfade_async", 0, leds, 8'h00);
        @(negedge CLK);
        RSTN = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge CLK);
            #1;
            check("midfade_after", k, leds, 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
